// File: rtl/i2c_cmos_sequencer.sv
// I2C slave sequencer for the CMOS/RTC register file (PCF8583 map at DEV_ADDR).
// Filters the pins, decodes START/STOP, and turns bus bytes into pointer loads, write strobes and read shifts.

module i2c_pin_filter #(
    parameter int DEB_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level
);
    localparam int CW = $clog2(DEB_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // The filtered level only follows the synchronised pin once it has
    // disagreed for DEB_LEN consecutive clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], pin};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module i2c_cmos_sequencer #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         DEB_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, WR_PTR, ACK_PTR, WR_DATA, ACK_DATA, RD_DATA, RD_ACK
    } state_t;

    state_t     state, state_n;
    logic [1:0] pins, filt, filt_q;
    logic       scl, sda, scl_rise, scl_fall, start, stop;
    logic [3:0] bit_cnt, cnt_n;
    logic [7:0] shreg, sh_n, ptr, ptr_n, wdata_n, rx_byte;
    logic       rw, rw_n, oe_n, we_n, busy_n, rd_load, byte_bit, byte_done;

    assign pins = {sda_in, scl_in};

    for (genvar i = 0; i < 2; i++) begin : g_pin
        i2c_pin_filter #(.DEB_LEN(DEB_LEN)) u_filt (
            .clk   (clk),
            .rst   (rst),
            .pin   (pins[i]),
            .level (filt[i])
        );
    end

    assign scl      = filt[0];
    assign sda      = filt[1];
    assign scl_rise = filt[0] & ~filt_q[0];
    assign scl_fall = ~filt[0] & filt_q[0];
    assign start    = ~filt[1] & filt_q[1] & scl;
    assign stop     = filt[1] & ~filt_q[1] & scl;

    assign rx_byte   = {shreg[6:0], sda};
    assign byte_bit  = scl_rise && (bit_cnt != 4'd8);
    assign byte_done = scl_fall && (bit_cnt == 4'd8);
    assign reg_addr  = ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q    <= 2'b11;
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            filt_q    <= filt;
            state     <= state_n;
            bit_cnt   <= cnt_n;
            shreg     <= sh_n;
            ptr       <= ptr_n;
            rw        <= rw_n;
            sda_oe    <= oe_n;
            reg_wdata <= wdata_n;
            reg_we    <= we_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        // The pointer steps in the clock after a write strobe.
        ptr_n   = reg_we ? ptr + 8'd1 : ptr;
        rw_n    = rw;
        oe_n    = sda_oe;
        wdata_n = reg_wdata;
        we_n    = 1'b0;
        busy_n  = busy;
        rd_load = 1'b0;

        if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            cnt_n   = '0;
        end else if (start) begin
            state_n = DEVADDR;
            oe_n    = 1'b0;
            cnt_n   = '0;
        end else begin
            case (state)
                DEVADDR: begin
                    if (byte_bit) begin
                        sh_n  = rx_byte;
                        cnt_n = bit_cnt + 4'd1;
                    end else if (byte_done) begin
                        cnt_n = '0;
                        if (shreg[7:1] == DEV_ADDR) begin
                            state_n = ACK_DEV;
                            oe_n    = 1'b1;
                            busy_n  = 1'b1;
                            rw_n    = shreg[0];
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                end
                WR_PTR: begin
                    if (byte_bit) begin
                        sh_n  = rx_byte;
                        cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) ptr_n = rx_byte;
                    end else if (byte_done) begin
                        cnt_n   = '0;
                        state_n = ACK_PTR;
                        oe_n    = 1'b1;
                    end
                end
                WR_DATA: begin
                    if (byte_bit) begin
                        sh_n  = rx_byte;
                        cnt_n = bit_cnt + 4'd1;
                    end else if (byte_done) begin
                        cnt_n   = '0;
                        state_n = ACK_DATA;
                        oe_n    = 1'b1;
                        wdata_n = shreg;
                        we_n    = 1'b1;
                    end
                end
                ACK_DEV: begin
                    if (scl_fall) begin
                        if (rw) begin
                            rd_load = 1'b1;
                        end else begin
                            state_n = WR_PTR;
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                        end
                    end
                end
                ACK_PTR, ACK_DATA: begin
                    if (scl_fall) begin
                        state_n = WR_DATA;
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                    end
                end
                RD_DATA: begin
                    // bit_cnt counts bits already put on the bus for this byte.
                    if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            rd_load = 1'b1;
                        end else if (bit_cnt == 4'd8) begin
                            state_n = RD_ACK;
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                        end else begin
                            oe_n  = ~shreg[6];
                            sh_n  = {shreg[6:0], 1'b0};
                            cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        ptr_n = ptr + 8'd1;
                        cnt_n = '0;
                        if (sda) begin
                            state_n = IDLE;
                            oe_n    = 1'b0;
                            busy_n  = 1'b0;
                        end else begin
                            state_n = RD_DATA;
                        end
                    end
                end
                default: ;
            endcase

            if (rd_load) begin
                state_n = RD_DATA;
                sh_n    = reg_rdata;
                oe_n    = ~reg_rdata[7];
                cnt_n   = 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_i2c_cmos_sequencer.sv
// Directed bench: a bit-banged I2C master and a 2-cycle-latency register file around the sequencer.
`timescale 1ns/1ps
module tb_i2c_cmos_sequencer;
    localparam int Q = 12;

    logic       clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_in, sda_in, sda_oe, reg_we, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata, rd_p1;
    logic [7:0] mem [256];
    bit         written [256];
    logic [7:0] log_addr [16], log_data [16];
    int         we_cnt = 0, oe_cnt = 0, checks = 0, errors = 0;
    logic       ack;
    logic [7:0] d0, d1;
    logic       b;
    int         oe0;

    always #5 clk = ~clk;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_cmos_sequencer #(.DEV_ADDR(7'h50), .DEB_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h02) ? 8'h3A : (a == 8'h03) ? 8'h17 : 8'h00;
    endfunction

    always @(posedge clk) begin
        rd_p1     <= written[reg_addr] ? mem[reg_addr] : init_val(reg_addr);
        reg_rdata <= rd_p1;
    end

    always @(negedge clk) begin
        if (reg_we) begin
            mem[reg_addr]     = reg_wdata;
            written[reg_addr] = 1'b1;
            if (we_cnt < 16) begin
                log_addr[we_cnt] = reg_addr;
                log_data[we_cnt] = reg_wdata;
            end
            we_cnt++;
        end
        if (sda_oe === 1'b1) oe_cnt++;
    end

    task automatic q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q();
    endtask

    // kind: 0 = plain, 1 = 2-clk SCL low glitch, 2 = 2-clk SDA glitch while SCL high
    task automatic write_bit(input logic v, input int kind);
        sda_m = v; q(); scl_m = 1'b1; q();
        if (kind == 1) begin
            scl_m = 1'b0; repeat (2) @(posedge clk); #1; scl_m = 1'b1;
        end else if (kind == 2) begin
            sda_m = ~v; repeat (2) @(posedge clk); #1; sda_m = v;
        end
        q(); scl_m = 1'b0; q();
    endtask

    task automatic read_bit(output logic v);
        sda_m = 1'b1; q(); scl_m = 1'b1; q(); v = sda_in; q(); scl_m = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        logic r;
        for (int i = 7; i >= 0; i--) write_bit(d[i], 0);
        read_bit(r);
        a = ~r;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic a);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            read_bit(r);
            d[i] = r;
        end
        write_bit(~a, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sda_oe", 16'(sda_oe), 16'h0);
        chk("rst_reg_addr", 16'(reg_addr), 16'h0);
        chk("rst_reg_we", 16'(reg_we), 16'h0);
        chk("rst_reg_wdata", 16'(reg_wdata), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        q();

        // Two-byte write from pointer 0x10
        i2c_start();
        write_byte(8'hA0, ack); chk("w1_ack_dev", 16'(ack), 16'h1);
        chk("w1_busy", 16'(busy), 16'h1);
        write_byte(8'h10, ack); chk("w1_ack_ptr", 16'(ack), 16'h1);
        write_byte(8'h55, ack); chk("w1_ack_d0", 16'(ack), 16'h1);
        write_byte(8'h66, ack); chk("w1_ack_d1", 16'(ack), 16'h1);
        i2c_stop();
        chk("w1_we_cnt", 16'(we_cnt), 16'd2);
        chk("w1_log0", {log_addr[0], log_data[0]}, 16'h1055);
        chk("w1_log1", {log_addr[1], log_data[1]}, 16'h1166);
        chk("w1_ptr", 16'(reg_addr), 16'h12);
        chk("w1_busy_end", 16'(busy), 16'h0);

        // Pointer set, repeated START, two-byte read
        i2c_start();
        write_byte(8'hA0, ack); chk("r_ack_dev", 16'(ack), 16'h1);
        write_byte(8'h02, ack); chk("r_ack_ptr", 16'(ack), 16'h1);
        i2c_start();
        write_byte(8'hA1, ack); chk("r_ack_rd", 16'(ack), 16'h1);
        read_byte(d0, 1'b1);
        read_byte(d1, 1'b0);
        chk("r_byte0", 16'(d0), 16'h3A);
        chk("r_byte1", 16'(d1), 16'h17);
        chk("r_busy_nack", 16'(busy), 16'h0);
        i2c_stop();
        chk("r_ptr", 16'(reg_addr), 16'h04);
        chk("r_no_we", 16'(we_cnt), 16'd2);

        // Address mismatch
        oe0 = oe_cnt;
        i2c_start();
        write_byte(8'hA4, ack); chk("mm_ack", 16'(ack), 16'h0);
        chk("mm_busy", 16'(busy), 16'h0);
        write_byte(8'h33, ack); chk("mm_ack2", 16'(ack), 16'h0);
        i2c_stop();
        chk("mm_no_oe", 16'(oe_cnt - oe0), 16'h0);
        chk("mm_no_we", 16'(we_cnt), 16'd2);

        // Pointer wrap FF -> 00
        i2c_start();
        write_byte(8'hA0, ack); chk("wr_ack_dev", 16'(ack), 16'h1);
        write_byte(8'hFF, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack); chk("wr_ack_d1", 16'(ack), 16'h1);
        i2c_stop();
        chk("wr_we_cnt", 16'(we_cnt), 16'd4);
        chk("wr_log2", {log_addr[2], log_data[2]}, 16'hFF11);
        chk("wr_log3", {log_addr[3], log_data[3]}, 16'h0022);
        chk("wr_ptr", 16'(reg_addr), 16'h01);

        // Reset in the middle of a read byte (regfile[05] = 00, so SDA is pulled low)
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h05, ack);
        i2c_start();
        write_byte(8'hA1, ack); chk("rr_ack_rd", 16'(ack), 16'h1);
        for (int i = 0; i < 3; i++) read_bit(b);
        sda_m = 1'b1; q(); scl_m = 1'b1; q();
        chk("rr_oe_before", 16'(sda_oe), 16'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rr_oe_after", 16'(sda_oe), 16'h0);
        chk("rr_ptr_after", 16'(reg_addr), 16'h00);
        chk("rr_busy_after", 16'(busy), 16'h0);
        scl_m = 1'b0; q();
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack); chk("rr_fresh_ack", 16'(ack), 16'h1);
        write_byte(8'h20, ack);
        write_byte(8'h99, ack); chk("rr_fresh_ackd", 16'(ack), 16'h1);
        i2c_stop();
        chk("rr_we_cnt", 16'(we_cnt), 16'd5);
        chk("rr_log4", {log_addr[4], log_data[4]}, 16'h2099);
        chk("rr_ptr_end", 16'(reg_addr), 16'h21);

        // Glitches on SCL and SDA while writing pointer 0x40
        i2c_start();
        write_byte(8'hA0, ack); chk("gl_ack_dev", 16'(ack), 16'h1);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] p;
            p = 8'h40;
            write_bit(p[i], (i == 5) ? 1 : (i == 6 || i == 3) ? 2 : 0);
        end
        read_bit(b); chk("gl_ack_ptr", 16'(b), 16'h0);
        chk("gl_busy", 16'(busy), 16'h1);
        write_byte(8'h77, ack); chk("gl_ack_d", 16'(ack), 16'h1);
        i2c_stop();
        chk("gl_we_cnt", 16'(we_cnt), 16'd6);
        chk("gl_log5", {log_addr[5], log_data[5]}, 16'h4077);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
